bit_stuffer: RTL and testbench



---
 rtl/bit_stuffer.sv | 103 ++++++++++
 tb/tb_bit_stuffer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/bit_stuffer.sv
// USB transmit bit stuffer: inserts a 0 after every STUFF_LEN consecutive 1s
// ahead of the NRZI encoder and stalls the serializer for each inserted bit.
module bit_stuffer #(
    parameter int unsigned STUFF_LEN = 6,
    parameter int unsigned CNT_W     = 3
) (
    input  logic       clk,
    input  logic       rst_b,
    input  logic       bstr_in,
    input  logic [1:0] bstr_in_ready,
    output logic       stall,
    output logic       bstr_out,
    output logic [1:0] bstr_out_ready,
    output logic       stuffed
);

    localparam int unsigned TYPE_W = 2;

    typedef enum logic {
        ST_PASS  = 1'b0,
        ST_STUFF = 1'b1
    } state_e;

    state_e              state_q,          state_d;
    logic [CNT_W-1:0]    ones_cnt_q,       ones_cnt_d;
    logic [TYPE_W-1:0]   held_type_q,      held_type_d;
    logic                bstr_out_q,       bstr_out_d;
    logic [TYPE_W-1:0]   bstr_out_ready_q, bstr_out_ready_d;
    logic                stuffed_q,        stuffed_d;
    logic [CNT_W-1:0]    cnt_inc;

    // State and output registers; reset discards any pending insertion.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q          <= ST_PASS;
            ones_cnt_q       <= '0;
            held_type_q      <= '0;
            bstr_out_q       <= 1'b1;
            bstr_out_ready_q <= '0;
            stuffed_q        <= 1'b0;
        end else begin
            state_q          <= state_d;
            ones_cnt_q       <= ones_cnt_d;
            held_type_q      <= held_type_d;
            bstr_out_q       <= bstr_out_d;
            bstr_out_ready_q <= bstr_out_ready_d;
            stuffed_q        <= stuffed_d;
        end
    end

    // Next-state and next-output decode.
    always_comb begin
        state_d          = state_q;
        ones_cnt_d       = ones_cnt_q;
        held_type_d      = held_type_q;
        bstr_out_d       = bstr_out_q;
        bstr_out_ready_d = bstr_out_ready_q;
        stuffed_d        = 1'b0;
        cnt_inc          = ones_cnt_q + CNT_W'(1);

        unique case (state_q)
            ST_PASS: begin
                if (bstr_in_ready != TYPE_W'(0)) begin
                    bstr_out_d       = bstr_in;
                    bstr_out_ready_d = bstr_in_ready;
                    if (bstr_in) begin
                        ones_cnt_d = cnt_inc;
                        // Run complete: emit a 0 next cycle under this packet's type.
                        if (cnt_inc == CNT_W'(STUFF_LEN)) begin
                            held_type_d = bstr_in_ready;
                            state_d     = ST_STUFF;
                        end
                    end else begin
                        ones_cnt_d = '0;
                    end
                end else begin
                    // Idle gap: line rests at 1 and runs never span packets.
                    bstr_out_d       = 1'b1;
                    bstr_out_ready_d = '0;
                    ones_cnt_d       = '0;
                end
            end
            ST_STUFF: begin
                // Inputs are held by upstream and ignored here.
                bstr_out_d       = 1'b0;
                bstr_out_ready_d = held_type_q;
                stuffed_d        = 1'b1;
                ones_cnt_d       = '0;
                state_d          = ST_PASS;
            end
            default: begin
                state_d = ST_PASS;
            end
        endcase
    end

    // Stall is a pure decode of the state register.
    assign stall          = (state_q == ST_STUFF);
    assign bstr_out       = bstr_out_q;
    assign bstr_out_ready = bstr_out_ready_q;
    assign stuffed        = stuffed_q;

endmodule

// File: tb/tb_bit_stuffer.sv
// Scoreboard bench for bit_stuffer: a stream-level model pushes the expected
// output symbol for every clock edge, and each DUT output is popped and compared.
module tb_bit_stuffer;

    localparam int unsigned STUFF_LEN = 6;

    logic       clk = 1'b0;
    logic       rst_b;
    logic       bstr_in;
    logic [1:0] bstr_in_ready;
    logic       stall;
    logic       bstr_out;
    logic [1:0] bstr_out_ready;
    logic       stuffed;

    typedef struct packed {
        logic       b;
        logic [1:0] t;
        logic       s;
    } sym_t;

    sym_t sb_q[$];

    int checks = 0;
    int errors = 0;

    // Model state: ones seen in the current run and a pending insertion.
    int         m_ones      = 0;
    logic       m_pend      = 1'b0;
    logic [1:0] m_held      = 2'b00;
    int         n_stall     = 0;
    int         n_stuffed   = 0;

    bit_stuffer #(.STUFF_LEN(STUFF_LEN), .CNT_W(3)) dut (
        .clk            (clk),
        .rst_b          (rst_b),
        .bstr_in        (bstr_in),
        .bstr_in_ready  (bstr_in_ready),
        .stall          (stall),
        .bstr_out       (bstr_out),
        .bstr_out_ready (bstr_out_ready),
        .stuffed        (stuffed)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ones = 0;
        m_pend = 1'b0;
        m_held = 2'b00;
        sb_q.delete();
    endtask

    // Present one upstream symbol until accepted (held through a stall cycle).
    task automatic send(input logic b, input logic [1:0] t);
        logic accepted;
        sym_t exp_sym;
        sym_t got_sym;
        accepted = 1'b0;
        while (!accepted) begin
            @(negedge clk);
            bstr_in       = b;
            bstr_in_ready = t;
            check("stall", 8'(stall), 8'(m_pend));
            if (stall) n_stall++;
            @(posedge clk);
            if (m_pend) begin
                sb_q.push_back('{b: 1'b0, t: m_held, s: 1'b1});
                m_pend = 1'b0;
                m_ones = 0;
            end else if (t != 2'b00) begin
                sb_q.push_back('{b: b, t: t, s: 1'b0});
                m_ones = b ? m_ones + 1 : 0;
                if (m_ones == STUFF_LEN) begin
                    m_pend = 1'b1;
                    m_held = t;
                end
                accepted = 1'b1;
            end else begin
                sb_q.push_back('{b: 1'b1, t: 2'b00, s: 1'b0});
                m_ones   = 0;
                accepted = 1'b1;
            end
            #1;
            if (sb_q.size() == 0) begin
                check("sb_empty", 8'd1, 8'd0);
            end else begin
                exp_sym = sb_q.pop_front();
                got_sym = '{b: bstr_out, t: bstr_out_ready, s: stuffed};
                check("bstr_out", 8'(got_sym.b), 8'(exp_sym.b));
                check("bstr_out_ready", 8'(got_sym.t), 8'(exp_sym.t));
                check("stuffed", 8'(got_sym.s), 8'(exp_sym.s));
                if (stuffed) n_stuffed++;
            end
        end
    endtask

    task automatic send_ones(input int n, input logic [1:0] t);
        for (int i = 0; i < n; i++) send(1'b1, t);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) send(1'b1, 2'b00);
    endtask

    task automatic clear_counts();
        n_stall   = 0;
        n_stuffed = 0;
    endtask

    initial begin
        rst_b         = 1'b0;
        bstr_in       = 1'b0;
        bstr_in_ready = 2'b00;
        #12;
        check("rst_stall", 8'(stall), 8'd0);
        check("rst_bstr_out", 8'(bstr_out), 8'd1);
        check("rst_ready", 8'(bstr_out_ready), 8'd0);
        check("rst_stuffed", 8'(stuffed), 8'd0);
        @(negedge clk);
        rst_b = 1'b1;
        idle(2);

        // 1: token, SYNC then 8 ones then 0.
        clear_counts();
        for (int i = 0; i < 7; i++) send(1'b0, 2'b01);
        send(1'b1, 2'b01);
        send_ones(8, 2'b01);
        send(1'b0, 2'b01);
        idle(2);
        check("t1_stuffed_cnt", 8'(n_stuffed), 8'd1);
        check("t1_stall_cnt", 8'(n_stall), 8'd1);

        // 2: data, runs of exactly five ones.
        clear_counts();
        for (int i = 0; i < 40; i++) send((i % 6) != 5, 2'b10);
        idle(2);
        check("t2_stuffed_cnt", 8'(n_stuffed), 8'd0);
        check("t2_stall_cnt", 8'(n_stall), 8'd0);

        // 3: handshake ending in six ones, idle right after.
        clear_counts();
        send(1'b0, 2'b11);
        send_ones(6, 2'b11);
        idle(3);
        check("t3_stuffed_cnt", 8'(n_stuffed), 8'd1);

        // 4: thirteen consecutive ones.
        clear_counts();
        send(1'b0, 2'b10);
        send_ones(13, 2'b10);
        send(1'b0, 2'b10);
        idle(2);
        check("t4_stuffed_cnt", 8'(n_stuffed), 8'd2);
        check("t4_stall_cnt", 8'(n_stall), 8'd2);

        // 5: idle gap splits a would-be run.
        clear_counts();
        send(1'b0, 2'b10);
        send_ones(4, 2'b10);
        idle(1);
        send_ones(3, 2'b01);
        send(1'b0, 2'b01);
        idle(2);
        check("t5_stuffed_cnt", 8'(n_stuffed), 8'd0);

        // 7: type change without idle keeps the run going.
        clear_counts();
        send_ones(3, 2'b10);
        send_ones(3, 2'b11);
        send(1'b0, 2'b11);
        idle(2);
        check("t7_stuffed_cnt", 8'(n_stuffed), 8'd1);

        // 6: reset during the stuff cycle.
        clear_counts();
        send(1'b0, 2'b10);
        send_ones(6, 2'b10);
        @(negedge clk);
        check("t6_pre_stall", 8'(stall), 8'd1);
        rst_b = 1'b0;
        #1;
        check("t6_rst_stall", 8'(stall), 8'd0);
        check("t6_rst_bstr_out", 8'(bstr_out), 8'd1);
        check("t6_rst_ready", 8'(bstr_out_ready), 8'd0);
        check("t6_rst_stuffed", 8'(stuffed), 8'd0);
        model_reset();
        @(posedge clk);
        #1;
        check("t6_hold_stuffed", 8'(stuffed), 8'd0);
        @(negedge clk);
        rst_b         = 1'b1;
        bstr_in_ready = 2'b00;
        clear_counts();
        idle(1);
        send_ones(6, 2'b10);
        send(1'b0, 2'b10);
        idle(2);
        check("t6_stuffed_cnt", 8'(n_stuffed), 8'd1);
        check("t6_stall_cnt", 8'(n_stall), 8'd1);
        check("sb_drained", 8'(sb_q.size()), 8'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
